// File: rtl/prince_pkg.sv
// Shared PRINCE S-box layer definitions: nibble substitution tables, mode encoding, FSM states.
package prince_pkg;

  // Nibble i of each table holds S(i) at bits [4i+3:4i].
  localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
  localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prince_sbox_nibble.sv
// Single 4-bit PRINCE S-box, forward or inverse by mode; purely combinational, no handshake.
module prince_sbox_nibble
  import prince_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (mode == MODE_INV) ? SBOX_INV[{din, 2'b00} +: 4]
                                   : SBOX_FWD[{din, 2'b00} +: 4];

endmodule

// File: rtl/prince_sbox_layer.sv
// PRINCE S-box layer, LANES nibbles per cycle; STEPS cycles from accept to out_valid.
// in_ready only in S_IDLE; result is held in S_DONE until out_ready.
module prince_sbox_layer
  import prince_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int STEPS   = (LANES > 0) ? NIBBLES / LANES : 1;
  localparam int CW      = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH % 4 != 0) || (LANES <= 0) || (NIBBLES % ((LANES > 0) ? LANES : 1) != 0)) begin : g_bad_param
    $error("prince_sbox_layer: WIDTH must be a multiple of 4 and WIDTH/4 divisible by LANES > 0");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] state_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic             last_step;
  logic [3:0]       lane_din  [LANES];
  logic [3:0]       lane_dout [LANES];

  assign last_step = (cnt == CW'(STEPS - 1));

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_din[j] = state_q[(int'(cnt) * LANES + j) * 4 +: 4];

    prince_sbox_nibble u_sbox (
      .mode (mode_q),
      .din  (lane_din[j]),
      .dout (lane_dout[j])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (last_step) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      state_q <= '0;
      mode_q  <= MODE_FWD;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_q <= in_data;
            mode_q  <= in_mode;
            cnt     <= '0;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            state_q[(int'(cnt) * LANES + j) * 4 +: 4] <= lane_dout[j];
          end
          // Hold at the last step so the lane mux never addresses past the state.
          if (!last_step) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = state_q;

endmodule

// File: tb/tb_prince_sbox_layer.sv
// Bench for prince_sbox_layer at LANES = 4, 16 and 1 against a table-lookup reference.
module tb_prince_sbox_layer;

  localparam logic [3:0] FWD_T [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
  localparam logic [3:0] INV_T [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        in_mode   [3];
  logic [63:0] in_data   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] out_data  [3];
  logic        busy      [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  prince_sbox_layer #(.WIDTH(64), .LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mode(in_mode[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  prince_sbox_layer #(.WIDTH(64), .LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mode(in_mode[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  prince_sbox_layer #(.WIDTH(64), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_mode(in_mode[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = m ? INV_T[d[4*i +: 4]] : FWD_T[d[4*i +: 4]];
    return r;
  endfunction

  function automatic int steps_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 1 : 16;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one state in at a negedge, waits for out_valid, optionally releases it.
  task automatic run(input int idx, input logic [63:0] d, input logic m, input bit release_out,
                     output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready[idx] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    in_mode[idx]  = m;
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[idx] && lat < 100);
    if (!out_valid[idx]) lat = -1;
    res = out_data[idx];
    if (release_out) begin
      out_ready[idx] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[idx] = 1'b0;
    end
  endtask

  logic [63:0] res, held, d;
  logic        m;
  int          lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_mode[i]   = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_in_ready[%0d]", i), 64'(in_ready[i]), 64'd1);
      chk($sformatf("reset_out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
      chk($sformatf("reset_busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("reset_out_data[%0d]", i), out_data[i], 64'd0);
    end
    rst_n = 1'b1;

    run(0, 64'h0123456789ABCDEF, 1'b0, 1'b1, res, lat);
    chk("l4_fwd_data", res, 64'hBF32AC916780E5D4);
    chk("l4_fwd_lat", 64'(lat), 64'd4);
    run(0, 64'hBF32AC916780E5D4, 1'b1, 1'b1, res, lat);
    chk("l4_inv_data", res, 64'h0123456789ABCDEF);
    chk("l4_inv_lat", 64'(lat), 64'd4);
    run(1, 64'd0, 1'b0, 1'b1, res, lat);
    chk("l16_zero_data", res, 64'hBBBBBBBBBBBBBBBB);
    chk("l16_zero_lat", 64'(lat), 64'd1);
    run(2, 64'd0, 1'b0, 1'b1, res, lat);
    chk("l1_zero_data", res, 64'hBBBBBBBBBBBBBBBB);
    chk("l1_zero_lat", 64'(lat), 64'd16);

    // Backpressure: hold the result while the producer keeps poking the input.
    run(0, 64'hDEADBEEF01234567, 1'b0, 1'b0, held, lat);
    chk("bp_first", held, ref_sub(64'hDEADBEEF01234567, 1'b0));
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0];
      in_data[0]  = {$urandom, $urandom};
      in_mode[0]  = 1'($urandom);
      @(negedge clk);
      chk("bp_hold_data", out_data[0], held);
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
    chk("bp_release_busy", 64'(busy[0]), 64'd0);

    // Input changes during S_BUSY must not leak into the running state.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 64'hFFFFFFFFFFFFFFFF;
    in_mode[0]  = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_mode[0]  = 1'b1;
    in_data[0]  = 64'h0123456789ABCDEF;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[0] && lat < 100);
    chk("midchange_data", out_data[0], 64'h4444444444444444);
    chk("midchange_lat", 64'(lat), 64'd4);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 64'h0123456789ABCDEF;
    in_mode[0]  = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid[0]), 64'd0);
    chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_out_data", out_data[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 64'h0123456789ABCDEF, 1'b0, 1'b1, res, lat);
    chk("after_abort_data", res, 64'hBF32AC916780E5D4);
    chk("after_abort_lat", 64'(lat), 64'd4);

    for (int idx = 0; idx < 3; idx++) begin
      for (int v = 0; v < 20; v++) begin
        d = {$urandom, $urandom};
        m = 1'($urandom);
        run(idx, d, m, 1'b1, res, lat);
        chk($sformatf("rand%0d_data m=%0d d=%h", idx, m, d), res, ref_sub(d, m));
        chk($sformatf("rand%0d_lat", idx), 64'(lat), 64'(steps_of(idx)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
